// File: rtl/priority_arbiter_4req.sv
// -----------------------------------------------------------------------------
// priority_arbiter_4req
//   Shares one resource among four requesters. In IDLE the highest-priority
//   requester wins and gets the grant one clock later. The owner keeps the
//   grant while it keeps requesting, for at most MAX_HOLD consecutive cycles.
//   When the owner drops its request or reaches its hold limit, the grant goes
//   straight to the next eligible requester with no idle cycle in between. If
//   nobody else is requesting, the arbiter returns to IDLE.
//
//   Build option: define ROUND_ROBIN_EN for rotating priority. The most recent
//   owner then becomes the lowest priority. Without it, priority is fixed at
//   3 > 2 > 1 > 0.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per owner (2..255)
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   req      in   4  request vector, bit i = requester i
//   gnt      out  4  registered one-hot grant, zero when idle
//   gnt_id   out  2  index of the current owner (meaningful while gnt_vld)
//   gnt_vld  out  1  any grant active (== |gnt)
//   expire   out  1  one-cycle pulse after a hold-limit release
// -----------------------------------------------------------------------------
module priority_arbiter_4req #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       expire
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             expire_q, expire_d;
`ifdef ROUND_ROBIN_EN
  logic [1:0]       last_id_q, last_id_d;
`endif

  logic [3:0] owner_oh;
  logic [3:0] elig;
  logic [1:0] win;
  logic       owner_req;
  logic       drop;
  logic       tmo;

`ifdef ROUND_ROBIN_EN
  // Search order is last-1, last-2, last-3, then last itself.
  // The scan runs from the lowest priority up, so the last hit wins.
  function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] cand;
    w = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last - 2'(k);
      if (e[cand]) w = cand;
    end
    return w;
  endfunction
`else
  // Fixed priority: the highest set index wins.
  function automatic logic [1:0] pick(input logic [3:0] e);
    logic [1:0] w;
    w = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (e[k]) w = 2'(k);
    end
    return w;
  endfunction
`endif

  // Decode the current owner into a one-hot mask.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_owner
      assign owner_oh[gi] = (gnt_id_q == 2'(gi));
    end
  endgenerate

  assign owner_req = |(req & owner_oh);
  assign drop      = !owner_req;
  assign tmo       = owner_req && (hold_cnt_q == HOLD_LAST);

  // In IDLE every requester is eligible. On a release, the outgoing owner is excluded.
  assign elig = (state_q == IDLE) ? req : (req & ~owner_oh);

`ifdef ROUND_ROBIN_EN
  assign win = pick(elig, last_id_q);
`else
  assign win = pick(elig);
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    expire_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_id_d  = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << win;
          gnt_id_d   = win;
          hold_cnt_d = '0;
`ifdef ROUND_ROBIN_EN
          last_id_d  = win;
`endif
        end else begin
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
        end
      end
      GRANT: begin
        if (drop || tmo) begin
          // A drop takes precedence: expire pulses only for a real timeout.
          expire_d = tmo;
          if (|elig) begin
            gnt_d      = 4'b0001 << win;
            gnt_id_d   = win;
            hold_cnt_d = '0;
`ifdef ROUND_ROBIN_EN
            last_id_d  = win;
`endif
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            gnt_id_d   = 2'd0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 4'b0000;
        gnt_id_d   = 2'd0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      hold_cnt_q <= '0;
      expire_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_id_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      expire_q   <= expire_d;
`ifdef ROUND_ROBIN_EN
      last_id_q  <= last_id_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = |gnt_q;
  assign expire  = expire_q;

endmodule

// File: tb/tb_priority_arbiter_4req.sv
// Self-checking bench for priority_arbiter_4req: directed scenarios plus
// randomized requests, compared against a transaction-level model of the
// arbitration rules. Define ROUND_ROBIN_EN here and in the RTL together.
module tb_priority_arbiter_4req;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       expire;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = idle), cycles held, last owner, expected expire.
  int m_owner  = -1;
  int m_cnt    = 0;
  int m_last   = 0;
  int m_expire = 0;

  priority_arbiter_4req #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .expire  (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner among the eligible requesters, following the priority rule of this build.
  function automatic int model_pick(input logic [3:0] e, input int last);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last - k + 8) % 4;
      if (e[idx]) return idx;
    end
    return -1;
`else
    for (int k = 3; k >= 0; k--) begin
      if (e[k]) return k;
    end
    return -1;
`endif
  endfunction

  // Advances the model by one clock edge, using the request value sampled at that edge.
  task automatic model_edge(input logic [3:0] r);
    int w;
    logic [3:0] e;
    m_expire = 0;
    if (m_owner < 0) begin
      if (r != 4'b0) begin
        w = model_pick(r, m_last);
        m_owner = w; m_cnt = 0; m_last = w;
      end
    end else begin
      if (!r[m_owner] || (m_cnt == MAX_HOLD - 1)) begin
        m_expire = r[m_owner] ? 1 : 0;
        e = r & ~(4'b0001 << m_owner);
        if (e != 4'b0) begin
          w = model_pick(e, m_last);
          m_owner = w; m_cnt = 0; m_last = w;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One cycle: drive req, pass the edge, compare against the model, print one line.
  task automatic step(input logic [3:0] r);
    logic [3:0] exp_gnt;
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("gnt_vld", 32'(gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_eq("expire", 32'(expire), 32'(m_expire));
    if (m_owner >= 0) check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
    $display("t=%0t req=%b gnt=%b id=%0d vld=%0d exp=%0d", $time, r, gnt, gnt_id, gnt_vld, expire);
  endtask

  // Asserts reset between clock edges and checks that the outputs clear before the next edge.
  task automatic apply_reset;
    rst_n = 1'b0;
    #2;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    check_eq("rst_gnt_id", 32'(gnt_id), 32'd0);
    check_eq("rst_expire", 32'(expire), 32'd0);
    m_owner = -1; m_cnt = 0; m_last = 0; m_expire = 0;
    rst_n = 1'b1;
    $display("t=%0t reset applied", $time);
  endtask

`ifdef ROUND_ROBIN_EN
  int exp_seq[5] = '{3, 2, 1, 0, 3};
`else
  int exp_seq[5] = '{3, 2, 3, 2, 3};
`endif

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Reset, then req=0101: requester 2 wins one cycle later.
    step(4'b0101);
    check_eq("t1_gnt", 32'(gnt), 32'h4);
    check_eq("t1_id", 32'(gnt_id), 32'd2);

    // Owner 2 drops while requester 0 asks: direct handover with no gap and no expire.
    step(4'b0100);
    step(4'b0001);
    check_eq("t2_gnt", 32'(gnt), 32'h1);
    check_eq("t2_expire", 32'(expire), 32'd0);

    // Lone requester 3 held: 8 grant cycles, one idle cycle with expire, then re-granted.
    apply_reset();
    for (int c = 0; c < MAX_HOLD; c++) begin
      step(4'b1000);
      check_eq("t3_hold", 32'(gnt), 32'h8);
    end
    step(4'b1000);
    check_eq("t3_idle", 32'(gnt), 32'h0);
    check_eq("t3_expire", 32'(expire), 32'd1);
    step(4'b1000);
    check_eq("t3_regrant", 32'(gnt), 32'h8);

    // Requesters 3 and 1 held: hold limit hands over to 1, with expire on the same cycle.
    apply_reset();
    for (int c = 0; c < MAX_HOLD; c++) begin
      step(4'b1010);
      check_eq("t4_hold", 32'(gnt), 32'h8);
    end
    step(4'b1010);
    check_eq("t4_handover", 32'(gnt), 32'h2);
    check_eq("t4_expire", 32'(expire), 32'd1);

    // All requesting: check the grant order, with each grant lasting MAX_HOLD cycles.
    apply_reset();
    step(4'b1111);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        check_eq("t5_order", 32'(gnt_id), 32'(exp_seq[g]));
        if (c == 0 && g > 0) check_eq("t5_expire", 32'(expire), 32'd1);
        step(4'b1111);
      end
    end

    // Reset mid-grant, then a fresh request from 1.
    apply_reset();
    step(4'b0100);
    step(4'b0100);
    apply_reset();
    step(4'b0010);
    check_eq("t6_gnt", 32'(gnt), 32'h2);

    // Randomized requests: sticky bits with rare flips, plus occasional clears and resets.
    r = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 49) == 0) r = 4'b0;
      if ($urandom_range(0, 399) == 0) apply_reset();
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
